// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// Module : npu_pkg
// Brief  : Shared NPU datapath widths and signed operand types.
// Rev    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package npu_pkg;

  localparam int ACT_W = 22;
  localparam int WGT_W = 22;
  localparam int ACC_W = 48;

  typedef logic signed [ACT_W-1:0] act_t;
  typedef logic signed [WGT_W-1:0] wgt_t;
  typedef logic signed [ACC_W-1:0] acc_t;

endpackage

`default_nettype wire

// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// Module : mac_unit
// Brief  : Two-stage signed multiply with combinational add of the running sum.
// Rev    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mac_unit
  import npu_pkg::*;
#(
  parameter int A_WIDTH   = ACT_W,
  parameter int B_WIDTH   = WGT_W,
  parameter int ACC_WIDTH = ACC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  input  logic signed [A_WIDTH-1:0]   data_in_a,
  input  logic signed [B_WIDTH-1:0]   data_in_b,
  input  logic signed [ACC_WIDTH-1:0] sum_in,
  output logic                        o_valid,
  output logic signed [ACC_WIDTH-1:0] sum_out
);

  localparam int P_W = A_WIDTH + B_WIDTH;

  logic signed [A_WIDTH-1:0]   r_a_q;
  logic signed [B_WIDTH-1:0]   r_b_q;
  logic signed [P_W-1:0]       r_prod_q;
  logic                        r_v1;
  logic                        r_v2;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;

  // Operand and product registers kept separate so the multiply maps onto a DSP slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_q    <= '0;
      r_b_q    <= '0;
      r_prod_q <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
    end else begin
      r_a_q    <= data_in_a;
      r_b_q    <= data_in_b;
      r_v1     <= i_valid;
      r_prod_q <= P_W'(r_a_q) * P_W'(r_b_q);
      r_v2     <= r_v1;
    end
  end

  // sum_in is taken in the output cycle so the caller's one-register feedback loop closes.
  assign w_prod_ext = ACC_WIDTH'(r_prod_q);
  assign o_valid    = r_v2;
  assign sum_out    = sum_in + (r_v2 ? w_prod_ext : '0);

endmodule

`default_nettype wire

// File: tb/tb_mac_unit.sv
// -----------------------------------------------------------------------------
// Module : tb_mac_unit
// Brief  : Scoreboard bench for mac_unit with caller-style registered feedback.
// Rev    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_mac_unit;
  import npu_pkg::*;

  typedef struct {
    bit      v;
    longint  p;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  act_t        data_in_a;
  wgt_t        data_in_b;
  acc_t        sum_in;
  logic        o_valid;
  acc_t        sum_out;

  acc_t        sum_fix;
  acc_t        acc;
  bit          fb_mode;
  acc_t        last_sum;
  int          pulses;
  int          n_tests;
  int          n_fail;
  beat_t       pipe[$];

  assign sum_in = fb_mode ? acc : sum_fix;

  always #5 clk = ~clk;

  mac_unit dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .data_in_a (data_in_a),
    .data_in_b (data_in_b),
    .sum_in    (sum_in),
    .o_valid   (o_valid),
    .sum_out   (sum_out)
  );

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, then check outputs of the beat issued two cycles ago.
  task automatic cycle(input bit r, input bit v, input int a, input int b);
    beat_t e;
    acc_t  es;
    rst       = r;
    i_valid   = v;
    data_in_a = act_t'(a);
    data_in_b = wgt_t'(b);
    if (r && pipe.size() > 0) pipe[pipe.size()-1].v = 1'b0;
    e.v = v && !r;
    e.p = longint'(a) * longint'(b);
    pipe.push_back(e);
    @(negedge clk);
    if (pipe.size() >= 3) begin
      e  = pipe.pop_front();
      es = sum_in + (e.v ? e.p[47:0] : 48'sd0);
      check_val("o_valid", longint'(o_valid), longint'(e.v));
      check_val("sum_out", longint'(sum_out), longint'(es));
    end
    if (o_valid) begin
      pulses++;
      last_sum = sum_out;
      acc      = sum_out;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    pulses   = 0;
    fb_mode  = 1'b0;
    sum_fix  = 48'sd100;
    acc      = '0;
    last_sum = '0;
    rst      = 1'b1;
    i_valid  = 1'b0;
    data_in_a = '0;
    data_in_b = '0;
    @(posedge clk);
    #1;

    // Reset, then a single beat against a held sum
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 0, 0);
    idle(2);
    check_val("reset_pulses", longint'(pulses), 0);
    cycle(1'b0, 1'b1, 3, -4);
    idle(4);
    check_val("single_sum", longint'(last_sum), 88);
    check_val("single_pulses", longint'(pulses), 1);

    // Back-to-back accumulation through the feedback register
    acc     = '0;
    pulses  = 0;
    fb_mode = 1'b1;
    for (int i = 0; i < 225; i++) cycle(1'b0, 1'b1, i, 1);
    idle(3);
    check_val("b2b_pulses", longint'(pulses), 225);
    check_val("b2b_total", longint'(acc), 25200);

    // Extreme operand signs
    fb_mode = 1'b0;
    sum_fix = '0;
    cycle(1'b0, 1'b1, -2097152, -2097152);
    idle(3);
    check_val("neg_neg", longint'(last_sum), 64'sd4398046511104);
    cycle(1'b0, 1'b1, -2097152, 2097151);
    idle(3);
    check_val("neg_pos", longint'(last_sum), -64'sd4398044413952);

    // Bubbles propagate exactly
    acc     = '0;
    pulses  = 0;
    fb_mode = 1'b1;
    cycle(1'b0, 1'b1, 2, 2);
    cycle(1'b0, 1'b0, 2, 2);
    cycle(1'b0, 1'b1, 2, 2);
    cycle(1'b0, 1'b1, 2, 2);
    cycle(1'b0, 1'b0, 2, 2);
    idle(3);
    check_val("bubble_pulses", longint'(pulses), 3);
    check_val("bubble_total", longint'(acc), 12);

    // Beats in flight are dropped by a mid-stream reset
    fb_mode = 1'b0;
    sum_fix = 48'sd7;
    pulses  = 0;
    cycle(1'b0, 1'b1, 5, 5);
    cycle(1'b1, 1'b1, 6, 6);
    cycle(1'b1, 1'b0, 0, 0);
    idle(4);
    check_val("rst_pulses", longint'(pulses), 0);
    cycle(1'b0, 1'b1, 1, 1);
    idle(3);
    check_val("post_rst_pulses", longint'(pulses), 1);
    check_val("post_rst_sum", longint'(last_sum), 8);

    // Wrap past the positive limit
    sum_fix = 48'sh7FFF_FFFF_FFFF;
    cycle(1'b0, 1'b1, 1, 1);
    idle(3);
    check_val("wrap", longint'(last_sum), -64'sd140737488355328);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
